// File: rtl/dcpu_lsu.sv
// rtl/dcpu_lsu.sv - dcpu load/store unit, Wishbone master with unaligned split support
module dcpu_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_done,
  output logic        o_error,
  output logic        o_busy,
  output logic [31:0] o_wb_addr,
  output logic        o_wb_cyc,
  output logic [3:0]  o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_PHASE1, S_PHASE2, S_DONE} state_t;

  state_t        state;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [1:0]    r_off;
  logic [31:0]   r_data;
  logic [31:0]   p1_raw;
  logic [TW-1:0] tmo_cnt;

  // Byte-lane mask for an access of the given size before lane shifting.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Lanes across the two consecutive words: [3:0] first word, [7:4] second.
  function automatic logic [7:0] lanes8(input logic [1:0] size, input logic [1:0] off);
    lanes8 = {4'b0000, size_mask(size)} << off;
  endfunction

  logic [3:0]  start_stb;
  logic [31:0] start_dat;
  logic [3:0]  p2_stb;
  logic [31:0] p2_dat;
  logic [31:0] rd_hi;
  logic [31:0] rd_lo;
  logic [31:0] rd_raw;
  logic [31:0] load_result;
  logic        tmo_hit;
  logic        phase_err;
  logic        phase_end;
  logic        go_phase2;

  // Lane placement for the first phase (from request inputs) and the second (from latched request).
  always_comb begin
    start_stb = 4'(lanes8(i_size, i_addr[1:0]));
    start_dat = i_data << {i_addr[1:0], 3'b000};
    p2_stb    = 4'(lanes8(r_size, r_off) >> 4);
    p2_dat    = 32'(({32'h0, r_data} << {r_off, 3'b000}) >> 32);
  end

  // Load assembly: the two bus words form a 64-bit window shifted down by the byte offset.
  always_comb begin
    rd_hi = 32'h0;
    rd_lo = i_wb_dat;
    if (state == S_PHASE2) begin
      rd_hi = i_wb_dat;
      rd_lo = p1_raw;
    end
    rd_raw = 32'({rd_hi, rd_lo} >> {r_off, 3'b000});
    case (r_size)
      2'b00:   load_result = {{24{r_signed & rd_raw[7]}}, rd_raw[7:0]};
      2'b01:   load_result = {{16{r_signed & rd_raw[15]}}, rd_raw[15:0]};
      default: load_result = rd_raw;
    endcase
  end

  // Phase termination decode; err outranks ack, ack outranks a coincident timeout.
  always_comb begin
    tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    phase_err = i_wb_err || (tmo_hit && !i_wb_ack);
    phase_end = i_wb_ack || phase_err;
    go_phase2 = (state == S_PHASE1) && i_wb_ack && !i_wb_err && (p2_stb != 4'b0000);
  end

  // Main sequencer with registered bus and handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      r_we      <= 1'b0;
      r_size    <= 2'b00;
      r_signed  <= 1'b0;
      r_off     <= 2'b00;
      r_data    <= 32'h0;
      p1_raw    <= 32'h0;
      tmo_cnt   <= '0;
      o_data    <= 32'h0;
      o_done    <= 1'b0;
      o_error   <= 1'b0;
      o_busy    <= 1'b0;
      o_wb_addr <= 32'h0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 4'b0000;
      o_wb_we   <= 1'b0;
      o_wb_dat  <= 32'h0;
    end else begin
      o_done  <= 1'b0;
      o_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            r_we     <= i_we;
            r_size   <= i_size;
            r_signed <= i_signed;
            r_off    <= i_addr[1:0];
            r_data   <= i_data;
            tmo_cnt  <= '0;
            o_busy   <= 1'b1;
            if (i_size == 2'b11) begin
              state   <= S_DONE;
              o_done  <= 1'b1;
              o_error <= 1'b1;
            end else begin
              state     <= S_PHASE1;
              o_wb_cyc  <= 1'b1;
              o_wb_addr <= {i_addr[31:2], 2'b00};
              o_wb_stb  <= start_stb;
              o_wb_dat  <= start_dat;
              o_wb_we   <= i_we;
            end
          end
        end
        S_PHASE1, S_PHASE2: begin
          if (go_phase2) begin
            state     <= S_PHASE2;
            p1_raw    <= i_wb_dat;
            tmo_cnt   <= '0;
            o_wb_addr <= o_wb_addr + 32'd4;
            o_wb_stb  <= p2_stb;
            o_wb_dat  <= p2_dat;
          end else if (phase_end) begin
            state    <= S_DONE;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 4'b0000;
            o_wb_we  <= 1'b0;
            o_done   <= 1'b1;
            o_error  <= phase_err;
            if (!phase_err && !r_we) begin
              o_data <= load_result;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcpu_lsu.sv
// tb/tb_dcpu_lsu.sv - directed self-checking bench for dcpu_lsu
module tb_dcpu_lsu;
  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_we, i_signed, i_wb_ack, i_wb_err;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_data, i_wb_dat;
  logic [31:0] o_data, o_wb_addr, o_wb_dat;
  logic        o_done, o_error, o_busy, o_wb_cyc, o_wb_we;
  logic [3:0]  o_wb_stb;
  int n_checks = 0;
  int n_pass = 0;

  always #5 i_clk = ~i_clk;

  dcpu_lsu #(.TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_we(i_we),
    .i_size(i_size), .i_signed(i_signed), .i_addr(i_addr), .i_data(i_data),
    .o_data(o_data), .o_done(o_done), .o_error(o_error), .o_busy(o_busy),
    .o_wb_addr(o_wb_addr), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] data);
    i_start  = 1'b1;
    i_we     = we;
    i_size   = size;
    i_signed = sgn;
    i_addr   = addr;
    i_data   = data;
    step();
    i_start  = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_we = 1'b0; i_signed = 1'b0; i_size = 2'b00;
    i_addr = 32'h0; i_data = 32'h0; i_wb_dat = 32'h0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    step(); step();
    i_reset = 1'b0;
    step();
    chk1("rst_cyc", o_wb_cyc, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_done", o_done, 1'b0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_stb", {28'h0, o_wb_stb}, 32'h0);

    // aligned word store, two wait states
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    chk1("st_cyc", o_wb_cyc, 1'b1);
    chk("st_addr", o_wb_addr, 32'h0000_0100);
    chk("st_stb", {28'h0, o_wb_stb}, 32'hF);
    chk("st_dat", o_wb_dat, 32'hDEAD_BEEF);
    chk1("st_we", o_wb_we, 1'b1);
    chk1("st_busy", o_busy, 1'b1);
    step();
    chk1("st_wait_done", o_done, 1'b0);
    step();
    i_wb_ack = 1'b1;
    step();
    i_wb_ack = 1'b0;
    chk1("st_done", o_done, 1'b1);
    chk1("st_err", o_error, 1'b0);
    chk1("st_cyc_off", o_wb_cyc, 1'b0);
    chk("st_odata", o_data, 32'h0);
    step();
    chk1("st_done_pulse", o_done, 1'b0);
    chk1("st_busy_off", o_busy, 1'b0);

    // signed byte load at lane 3, latency start/phase/done
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0);
    chk("lb_addr", o_wb_addr, 32'h0000_0200);
    chk("lb_stb", {28'h0, o_wb_stb}, 32'h8);
    chk1("lb_we", o_wb_we, 1'b0);
    i_wb_ack = 1'b1; i_wb_dat = 32'h80FF_FFFF;
    step();
    i_wb_ack = 1'b0;
    chk1("lb_done", o_done, 1'b1);
    chk("lb_sdata", o_data, 32'hFFFF_FF80);
    step();

    // unsigned repeat
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0);
    i_wb_ack = 1'b1; i_wb_dat = 32'h80FF_FFFF;
    step();
    i_wb_ack = 1'b0;
    chk1("lbu_done", o_done, 1'b1);
    chk("lbu_data", o_data, 32'h0000_0080);
    step();

    // unaligned word load across a word boundary; request inputs scrambled after start
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0FFE, 32'h0);
    i_addr = 32'hDEAD_0001; i_size = 2'b00; i_we = 1'b1; i_signed = 1'b1;
    chk("ul_p1_addr", o_wb_addr, 32'h0000_0FFC);
    chk("ul_p1_stb", {28'h0, o_wb_stb}, 32'hC);
    i_wb_ack = 1'b1; i_wb_dat = 32'h1234_ABCD;
    step();
    i_wb_ack = 1'b0;
    chk1("ul_p2_cyc", o_wb_cyc, 1'b1);
    chk1("ul_p2_nodone", o_done, 1'b0);
    chk("ul_p2_addr", o_wb_addr, 32'h0000_1000);
    chk("ul_p2_stb", {28'h0, o_wb_stb}, 32'h3);
    i_wb_ack = 1'b1; i_wb_dat = 32'h9ABC_5678;
    step();
    i_wb_ack = 1'b0;
    chk1("ul_done", o_done, 1'b1);
    chk("ul_data", o_data, 32'h5678_1234);
    step();

    // unaligned half store at the top of memory, with a stray start while busy
    issue(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_AABB);
    chk("us_p1_addr", o_wb_addr, 32'hFFFF_FFFC);
    chk("us_p1_stb", {28'h0, o_wb_stb}, 32'h8);
    chk("us_p1_dat", o_wb_dat, 32'hBB00_0000);
    i_start = 1'b1; i_size = 2'b11;
    step();
    i_start = 1'b0;
    chk1("us_busy_ign", o_wb_cyc, 1'b1);
    chk("us_busy_addr", o_wb_addr, 32'hFFFF_FFFC);
    i_wb_ack = 1'b1;
    step();
    i_wb_ack = 1'b0;
    chk("us_p2_addr", o_wb_addr, 32'h0000_0000);
    chk("us_p2_stb", {28'h0, o_wb_stb}, 32'h1);
    chk("us_p2_dat", o_wb_dat, 32'h0000_00AA);
    chk1("us_p2_we", o_wb_we, 1'b1);
    i_wb_ack = 1'b1;
    step();
    i_wb_ack = 1'b0;
    chk1("us_done", o_done, 1'b1);
    chk1("us_err", o_error, 1'b0);
    chk("us_odata", o_data, 32'h5678_1234);
    step();
    chk1("us_idle_cyc", o_wb_cyc, 1'b0);
    chk1("us_idle_busy", o_busy, 1'b0);

    // err together with ack on phase 1 of a split load
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0);
    chk("e1_stb", {28'h0, o_wb_stb}, 32'hC);
    i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_dat = 32'h0BAD_0BAD;
    step();
    i_wb_ack = 1'b0; i_wb_err = 1'b0;
    chk1("e1_done", o_done, 1'b1);
    chk1("e1_err", o_error, 1'b1);
    chk1("e1_cyc", o_wb_cyc, 1'b0);
    chk("e1_odata", o_data, 32'h5678_1234);
    step();
    chk1("e1_no_p2", o_wb_cyc, 1'b0);
    chk1("e1_pulse", o_error, 1'b0);

    // reserved size
    issue(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0);
    chk1("rs_done", o_done, 1'b1);
    chk1("rs_err", o_error, 1'b1);
    chk1("rs_cyc", o_wb_cyc, 1'b0);
    chk1("rs_busy", o_busy, 1'b1);
    step();
    chk1("rs_cyc2", o_wb_cyc, 1'b0);
    chk1("rs_busy2", o_busy, 1'b0);

    // timeout after four silent phase cycles
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    chk1("to_cyc", o_wb_cyc, 1'b1);
    step(); step(); step();
    chk1("to_c4_nodone", o_done, 1'b0);
    chk1("to_c4_cyc", o_wb_cyc, 1'b1);
    step();
    chk1("to_done", o_done, 1'b1);
    chk1("to_err", o_error, 1'b1);
    chk1("to_cyc_off", o_wb_cyc, 1'b0);
    step();

    // reset during phase 2, then a late ack in idle, then a normal byte load
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0403, 32'h0);
    chk("rp_p1_stb", {28'h0, o_wb_stb}, 32'h8);
    i_wb_ack = 1'b1; i_wb_dat = 32'h1100_0000;
    step();
    i_wb_ack = 1'b0;
    chk("rp_p2_addr", o_wb_addr, 32'h0000_0404);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk1("rp_cyc", o_wb_cyc, 1'b0);
    chk1("rp_busy", o_busy, 1'b0);
    chk1("rp_done", o_done, 1'b0);
    chk("rp_odata", o_data, 32'h0);
    i_wb_ack = 1'b1;
    step();
    i_wb_ack = 1'b0;
    chk1("late_ack_done", o_done, 1'b0);
    chk1("late_ack_busy", o_busy, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0301, 32'h0);
    chk("pb_addr", o_wb_addr, 32'h0000_0300);
    chk("pb_stb", {28'h0, o_wb_stb}, 32'h2);
    i_wb_ack = 1'b1; i_wb_dat = 32'h0000_A500;
    step();
    i_wb_ack = 1'b0;
    chk1("pb_done", o_done, 1'b1);
    chk1("pb_err", o_error, 1'b0);
    chk("pb_data", o_data, 32'h0000_00A5);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
